btn_event_gen: RTL and testbench

- Sits directly downstream of the 4-button debouncer bank. Consumes the 4-bit debounced level vector: [3]=UP, [2]=DOWN, [1]=LEFT, [0]=RIGHT.
- Converts each level into single-cycle events for the watch mode/set controller: press, short-release, long-press and auto-repeat.
- Contains four independent per-button FSMs, each with its own hold counter.

---
 rtl/btn_event_gen.sv | 86 ++++++++
 tb/tb_btn_event_gen.sv | 121 ++++++++++++
 2 files changed

// File: rtl/btn_event_gen.sv
// btn_event_gen: turns four debounced button levels into press/short/long/repeat pulses
module btn_event_gen #(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_debounced_btn,
    output logic [3:0] o_btn_press,
    output logic [3:0] o_btn_short,
    output logic [3:0] o_btn_long,
    output logic [3:0] o_btn_repeat,
    output logic [3:0] o_btn_held
);
    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESSED = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;

    genvar i;
    for (i = 0; i < 4; i++) begin : g_btn
        logic          w_in;
        logic [1:0]    r_state, w_nxt;
        logic [CW-1:0] r_cnt, w_cnt;
        logic          w_press, w_short, w_long, w_rep;
        logic          r_press, r_short, r_long, r_rep, r_held;

        assign w_in = i_debounced_btn[i];

        // Next state: release takes priority over both the long and repeat thresholds
        always_comb begin
            w_nxt   = r_state;
            w_cnt   = r_cnt + CW'(1);
            w_press = 1'b0;
            w_short = 1'b0;
            w_long  = 1'b0;
            w_rep   = 1'b0;
            if (r_state == IDLE) begin
                w_nxt   = w_in ? PRESSED : IDLE;
                w_cnt   = w_in ? CW'(1) : '0;
                w_press = w_in;
            end else if (!w_in) begin
                w_nxt   = IDLE;
                w_cnt   = '0;
                w_short = (r_state == PRESSED);
            end else if (r_state == PRESSED && r_cnt == LONG_LAST) begin
                w_nxt  = HELD;
                w_cnt  = '0;
                w_long = 1'b1;
            end else if (r_state == HELD && r_cnt == REP_LAST) begin
                w_cnt = '0;
                w_rep = 1'b1;
            end
        end

        // State, counter and registered event outputs; held mirrors the next state so it rises with press
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_press <= 1'b0;
                r_short <= 1'b0;
                r_long  <= 1'b0;
                r_rep   <= 1'b0;
                r_held  <= 1'b0;
            end else begin
                r_state <= w_nxt;
                r_cnt   <= w_cnt;
                r_press <= w_press;
                r_short <= w_short;
                r_long  <= w_long;
                r_rep   <= w_rep;
                r_held  <= (w_nxt != IDLE);
            end
        end

        assign o_btn_press[i]  = r_press;
        assign o_btn_short[i]  = r_short;
        assign o_btn_long[i]   = r_long;
        assign o_btn_repeat[i] = r_rep;
        assign o_btn_held[i]   = r_held;
    end
endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: directed checks of btn_event_gen with LONG_CYCLES=8, REPEAT_CYCLES=4
module tb_btn_event_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] i_debounced_btn = 4'b1111;
    logic [3:0] o_btn_press, o_btn_short, o_btn_long, o_btn_repeat, o_btn_held;
    int n_asserts = 0;
    int n_fail = 0;

    btn_event_gen #(.LONG_CYCLES(8), .REPEAT_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .i_debounced_btn(i_debounced_btn),
        .o_btn_press(o_btn_press),
        .o_btn_short(o_btn_short),
        .o_btn_long(o_btn_long),
        .o_btn_repeat(o_btn_repeat),
        .o_btn_held(o_btn_held)
    );

    always #5 clk = ~clk;

    // Apply one input sample and settle just after the edge that consumes it
    task automatic cyc(input logic [3:0] v);
        i_debounced_btn = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] ep, es, el, er, eh);
        n_asserts++;
        assert (o_btn_press === ep) else begin n_fail++; $error("FAIL %s press: got %b exp %b", tag, o_btn_press, ep); end
        n_asserts++;
        assert (o_btn_short === es) else begin n_fail++; $error("FAIL %s short: got %b exp %b", tag, o_btn_short, es); end
        n_asserts++;
        assert (o_btn_long === el) else begin n_fail++; $error("FAIL %s long: got %b exp %b", tag, o_btn_long, el); end
        n_asserts++;
        assert (o_btn_repeat === er) else begin n_fail++; $error("FAIL %s repeat: got %b exp %b", tag, o_btn_repeat, er); end
        n_asserts++;
        assert (o_btn_held === eh) else begin n_fail++; $error("FAIL %s held: got %b exp %b", tag, o_btn_held, eh); end
    endtask

    initial begin
        // 1. reset with all buttons high, then first press after release
        repeat (3) cyc(4'b1111);
        chk("reset", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        rst = 1'b0;
        cyc(4'b1111);
        chk("post_rst_press", 4'b1111, 4'b0, 4'b0, 4'b0, 4'b1111);
        cyc(4'b0000);
        chk("post_rst_short", 4'b0, 4'b1111, 4'b0, 4'b0, 4'b0);
        cyc(4'b0000);
        chk("idle1", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

        // 2. short press on bit0
        cyc(4'b0001);
        chk("short_press", 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0001);
        cyc(4'b0001);
        chk("short_hold1", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0001);
        cyc(4'b0001);
        chk("short_hold2", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0001);
        cyc(4'b0000);
        chk("short_rel", 4'b0, 4'b0001, 4'b0, 4'b0, 4'b0);
        cyc(4'b0000);
        chk("idle2", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

        // 3. long press with repeats on bit3
        for (int k = 0; k < 20; k++) begin
            cyc(4'b1000);
            chk($sformatf("long_k%0d", k), (k == 0) ? 4'b1000 : 4'b0, 4'b0,
                (k == 7) ? 4'b1000 : 4'b0,
                (k == 11 || k == 15 || k == 19) ? 4'b1000 : 4'b0, 4'b1000);
        end
        cyc(4'b0000);
        chk("long_rel", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

        // 4. release on the long-threshold edge yields short only
        for (int k = 0; k < 7; k++) begin
            cyc(4'b0100);
            chk($sformatf("race_k%0d", k), (k == 0) ? 4'b0100 : 4'b0, 4'b0, 4'b0, 4'b0, 4'b0100);
        end
        cyc(4'b0000);
        chk("race_rel", 4'b0, 4'b0100, 4'b0, 4'b0, 4'b0);
        cyc(4'b0000);
        chk("race_idle", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

        // 5. staggered independent holds on bits 1 and 0
        for (int k = 0; k < 12; k++) begin
            logic b1, b0;
            b1 = (k <= 9);
            b0 = (k >= 2);
            cyc({2'b00, b1, b0});
            chk($sformatf("indep_k%0d", k),
                {2'b00, k == 0, k == 2}, 4'b0,
                {2'b00, k == 7, k == 9}, 4'b0, {2'b00, b1, b0});
        end
        cyc(4'b0000);
        chk("indep_rel", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

        // 6. reset in the middle of a HELD hold, then fresh press and long restart
        for (int k = 0; k < 10; k++) begin
            cyc(4'b1000);
            chk($sformatf("mid_k%0d", k), (k == 0) ? 4'b1000 : 4'b0, 4'b0,
                (k == 7) ? 4'b1000 : 4'b0, 4'b0, 4'b1000);
        end
        rst = 1'b1;
        cyc(4'b1000);
        chk("mid_rst", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cyc(4'b1000);
            chk($sformatf("restart_k%0d", k), (k == 0) ? 4'b1000 : 4'b0, 4'b0,
                (k == 7) ? 4'b1000 : 4'b0, 4'b0, 4'b1000);
        end
        cyc(4'b0000);
        chk("restart_rel", 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
